mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 22 ++
 rtl/mult_div_unit_if.sv | 18 +
 rtl/mult_div_unit_div_step.sv | 28 ++
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and sizes for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ITERS  = 32;
  localparam int CNT_W  = $clog2(ITERS) + 1;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic              start;
  logic              op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              div0;

  modport master (output start, op, a, b, input busy, done, hi, lo, div0);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, div0);

endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step
  import mult_div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_dvs,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quo
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_quo[DATA_W-1]};
    w_diff  = w_shift - {1'b0, i_dvs};
    // Remainder stays below the divisor, so a set top bit means a borrow.
    if (w_diff[DATA_W]) begin
      o_rem = w_shift[DATA_W-1:0];
      o_quo = {i_quo[DATA_W-2:0], 1'b0};
    end else begin
      o_rem = w_diff[DATA_W-1:0];
      o_quo = {i_quo[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit with HI/LO results.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_mq;
  logic               r_qm1;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;
  logic               r_div0;
  logic [DATA_W-1:0]  r_hi;
  logic [DATA_W-1:0]  r_lo;

  logic signed [DATA_W:0] w_acc_ext;
  logic signed [DATA_W:0] w_mcand_ext;
  logic signed [DATA_W:0] w_sum;
  logic [DATA_W-1:0]      w_booth_acc;
  logic [DATA_W-1:0]      w_booth_mq;
  logic [DATA_W-1:0]      w_rem;
  logic [DATA_W-1:0]      w_quo;
  logic [DATA_W-1:0]      w_hi_div;
  logic [DATA_W-1:0]      w_lo_div;
  logic                   w_last;

  // Booth add/sub is done one bit wider so the most negative multiplicand cannot overflow.
  always_comb begin
    w_acc_ext   = $signed({r_acc[DATA_W-1], r_acc});
    w_mcand_ext = $signed({r_a[DATA_W-1], r_a});
    w_sum       = w_acc_ext;
    case ({r_mq[0], r_qm1})
      2'b01:   w_sum = w_acc_ext + w_mcand_ext;
      2'b10:   w_sum = w_acc_ext - w_mcand_ext;
      default: w_sum = w_acc_ext;
    endcase
    w_booth_acc = w_sum[DATA_W:1];
    w_booth_mq  = {w_sum[0], r_mq[DATA_W-1:1]};
  end

  div_step u_div_step (
    .i_rem (r_acc),
    .i_quo (r_mq),
    .i_dvs (r_b),
    .o_rem (w_rem),
    .o_quo (w_quo)
  );

  assign w_lo_div = r_neg_q ? (~w_quo + DATA_W'(1)) : w_quo;
  assign w_hi_div = r_neg_r ? (~w_rem + DATA_W'(1)) : w_rem;
  assign w_last   = (r_cnt == CNT_W'(ITERS - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_qm1   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_qm1   <= 1'b0;
            r_neg_q <= bus.a[DATA_W-1] ^ bus.b[DATA_W-1];
            r_neg_r <= bus.a[DATA_W-1];
            r_busy  <= 1'b1;
            if (bus.op == OP_DIV) begin
              r_a  <= bus.a;
              r_mq <= f_mag(bus.a);
              r_b  <= f_mag(bus.b);
              if (bus.b == '0) begin
                r_state <= ST_FINISH;
                r_done  <= 1'b1;
                r_div0  <= 1'b1;
              end else begin
                r_state <= ST_RUN;
              end
            end else begin
              r_a     <= bus.a;
              r_mq    <= bus.b;
              r_b     <= bus.b;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op == OP_MULT) begin
            r_acc <= w_booth_acc;
            r_mq  <= w_booth_mq;
            r_qm1 <= r_mq[0];
          end else begin
            r_acc <= w_rem;
            r_mq  <= w_quo;
          end
          // Final iteration feeds the result registers directly, sign-corrected for DIV.
          if (w_last) begin
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
            r_div0  <= 1'b0;
            if (r_op == OP_MULT) begin
              r_hi <= w_booth_acc;
              r_lo <= w_booth_mq;
            end else begin
              r_hi <= w_hi_div;
              r_lo <= w_lo_div;
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_div0  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_div0  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.div0 = r_div0;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
